// File: rtl/flex_bit_timer_if.sv
// Handshake/config bundle between the receiver control unit and the bit timer.
// The master drives enable and configuration; the slave (timer) returns strobes and status.
interface flex_bit_timer_if #(
  parameter int unsigned CNT_W = 8,
  parameter int unsigned BIT_W = 4
);
  logic             enable_timer;
  logic [CNT_W-1:0] clks_per_bit;
  logic [CNT_W-1:0] sample_point;
  logic [BIT_W-1:0] bits_per_packet;
  logic             shift_enable;
  logic             packet_done;
  logic [BIT_W-1:0] bit_index;
  logic             busy;
  logic             cfg_error;

  modport master (
    output enable_timer, clks_per_bit, sample_point, bits_per_packet,
    input  shift_enable, packet_done, bit_index, busy, cfg_error
  );

  modport slave (
    input  enable_timer, clks_per_bit, sample_point, bits_per_packet,
    output shift_enable, packet_done, bit_index, busy, cfg_error
  );
endinterface

// File: rtl/flex_bit_timer.sv
// Programmable bit-timing generator for the serial receive path: produces sample ticks
// every P clocks at offset S for N samples per packet, with abort and config checking.
module flex_bit_timer #(
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned BIT_W      = 4,
  parameter bit          SKIP_START = 1'b1
) (
  input  logic             clk,
  input  logic             n_rst,
  flex_bit_timer_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q;
  logic [CNT_W-1:0] clk_cnt_q;
  logic [CNT_W-1:0] p_q;
  logic [CNT_W-1:0] s_q;
  logic [BIT_W-1:0] n_q;
  logic [BIT_W-1:0] bit_cnt_q;

  logic cfg_ok;
  logic sample_tick;
  logic last_sample;

  assign cfg_ok = (bus.clks_per_bit > CNT_W'(1)) &&
                  (bus.sample_point != '0) &&
                  (bus.sample_point <= bus.clks_per_bit) &&
                  (bus.bits_per_packet != '0);

  assign sample_tick = (state_q == StRun) && (clk_cnt_q == s_q);
  assign last_sample = (bit_cnt_q == n_q - BIT_W'(1));

  // The start-bit sample still advances bit_cnt even when it produces no shift.
  assign bus.shift_enable = sample_tick && (!SKIP_START || (bit_cnt_q != '0));
  assign bus.cfg_error    = (state_q == StIdle) && bus.enable_timer && !cfg_ok;
  assign bus.packet_done  = (state_q == StDone);
  assign bus.busy         = (state_q == StRun);
  assign bus.bit_index    = bit_cnt_q;

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q   <= StIdle;
      clk_cnt_q <= '0;
      bit_cnt_q <= '0;
      p_q       <= '0;
      s_q       <= '0;
      n_q       <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.enable_timer && cfg_ok) begin
            state_q   <= StRun;
            p_q       <= bus.clks_per_bit;
            s_q       <= bus.sample_point;
            n_q       <= bus.bits_per_packet;
            clk_cnt_q <= CNT_W'(1);
            bit_cnt_q <= '0;
          end
        end
        StRun: begin
          // Abort wins over a coincident tick.
          if (!bus.enable_timer) begin
            state_q   <= StIdle;
            clk_cnt_q <= '0;
            bit_cnt_q <= '0;
          end else begin
            clk_cnt_q <= (clk_cnt_q == p_q) ? CNT_W'(1) : clk_cnt_q + CNT_W'(1);
            if (sample_tick) begin
              bit_cnt_q <= bit_cnt_q + BIT_W'(1);
              if (last_sample) begin
                state_q   <= StDone;
                clk_cnt_q <= '0;
              end
            end
          end
        end
        StDone: begin
          if (!bus.enable_timer) begin
            state_q   <= StIdle;
            clk_cnt_q <= '0;
            bit_cnt_q <= '0;
          end
        end
        default: begin
          state_q   <= StIdle;
          clk_cnt_q <= '0;
          bit_cnt_q <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_flex_bit_timer.sv
// Bench for flex_bit_timer: two instances (start-bit skip on/off) share stimulus and are
// compared each cycle against an arithmetic model of packet timing.
module tb_flex_bit_timer;
  localparam int unsigned CNT_W = 8;
  localparam int unsigned BIT_W = 4;

  logic clk = 1'b0;
  logic n_rst;
  logic en;
  int   cfg_p, cfg_s, cfg_n;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  flex_bit_timer_if #(.CNT_W(CNT_W), .BIT_W(BIT_W)) bus_skip ();
  flex_bit_timer_if #(.CNT_W(CNT_W), .BIT_W(BIT_W)) bus_noskip ();

  assign bus_skip.enable_timer      = en;
  assign bus_skip.clks_per_bit      = CNT_W'(cfg_p);
  assign bus_skip.sample_point      = CNT_W'(cfg_s);
  assign bus_skip.bits_per_packet   = BIT_W'(cfg_n);
  assign bus_noskip.enable_timer    = en;
  assign bus_noskip.clks_per_bit    = CNT_W'(cfg_p);
  assign bus_noskip.sample_point    = CNT_W'(cfg_s);
  assign bus_noskip.bits_per_packet = BIT_W'(cfg_n);

  flex_bit_timer #(.CNT_W(CNT_W), .BIT_W(BIT_W), .SKIP_START(1'b1)) u_dut_skip (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus_skip)
  );

  flex_bit_timer #(.CNT_W(CNT_W), .BIT_W(BIT_W), .SKIP_START(1'b0)) u_dut_noskip (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus_noskip)
  );

  // Model: mode 0 idle, 1 running, 2 done; k = RUN cycle number starting at 1.
  int m_mode = 0;
  int m_k = 0;
  int m_p = 0, m_s = 0, m_n = 0;

  int e_tick, e_idx, e_shift_skip, e_shift_noskip, e_done, e_busy, e_cfgerr;

  function automatic int cfg_legal(int p, int s, int n);
    return (p >= 2 && p <= 255 && s >= 1 && s <= p && n >= 1 && n <= 15) ? 1 : 0;
  endfunction

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  task automatic compute_expected();
    int taken;
    e_tick = 0;
    taken  = 0;
    if (m_mode == 1) begin
      // Samples land on RUN cycles S, S+P, S+2P, ...
      if (m_k >= m_s) begin
        taken  = (m_k - m_s) / m_p;
        e_tick = ((m_k - m_s) % m_p == 0) ? 1 : 0;
      end
      if (m_k >= m_s && e_tick == 0) taken = taken + 1;
    end
    e_idx          = (m_mode == 2) ? m_n : (m_mode == 1) ? taken : 0;
    e_shift_noskip = e_tick;
    e_shift_skip   = (e_tick != 0 && e_idx != 0) ? 1 : 0;
    e_done         = (m_mode == 2) ? 1 : 0;
    e_busy         = (m_mode == 1) ? 1 : 0;
    e_cfgerr       = (m_mode == 0 && en && !cfg_legal(cfg_p, cfg_s, cfg_n)) ? 1 : 0;
  endtask

  task automatic model_edge();
    if (!n_rst) begin
      m_mode = 0;
      m_k    = 0;
      m_p    = 0;
      m_s    = 0;
      m_n    = 0;
    end else if (m_mode == 0) begin
      if (en && cfg_legal(cfg_p, cfg_s, cfg_n) != 0) begin
        m_mode = 1;
        m_k    = 1;
        m_p    = cfg_p;
        m_s    = cfg_s;
        m_n    = cfg_n;
      end
    end else if (m_mode == 1) begin
      if (!en) m_mode = 0;
      else if (e_tick != 0 && e_idx == m_n - 1) m_mode = 2;
      else m_k++;
    end else begin
      if (!en) m_mode = 0;
    end
  endtask

  // Called at a falling edge with inputs already driven for this cycle.
  task automatic cycle();
    #1;
    compute_expected();
    check_eq("shift_enable_skip",   int'(bus_skip.shift_enable),   e_shift_skip);
    check_eq("shift_enable_noskip", int'(bus_noskip.shift_enable), e_shift_noskip);
    check_eq("packet_done",         int'(bus_skip.packet_done),    e_done);
    check_eq("bit_index",           int'(bus_skip.bit_index),      e_idx);
    check_eq("bit_index_noskip",    int'(bus_noskip.bit_index),    e_idx);
    check_eq("busy",                int'(bus_skip.busy),           e_busy);
    check_eq("cfg_error",           int'(bus_skip.cfg_error),      e_cfgerr);
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic set_cfg(input int p, input int s, input int n);
    cfg_p = p;
    cfg_s = s;
    cfg_n = n;
  endtask

  int shift_count;

  initial begin
    n_rst = 1'b0;
    en    = 1'b0;
    set_cfg(10, 3, 10);
    @(negedge clk);
    run(2);
    n_rst = 1'b1;
    run(2);

    // Full default packet, counting shifts directly against the expected nine.
    en = 1'b1;
    shift_count = 0;
    repeat (100) begin
      if (bus_skip.shift_enable) shift_count++;
      cycle();
    end
    check_eq("default_shift_count", shift_count, 9);
    check_eq("default_done_held", int'(bus_skip.packet_done), 1);
    check_eq("default_index_held", int'(bus_skip.bit_index), 10);
    en = 1'b0;
    run(3);

    // Abort mid-packet, then a clean packet.
    en = 1'b1;
    run(41);
    en = 1'b0;
    run(2);
    en = 1'b1;
    run(100);
    en = 1'b0;
    run(2);

    // Reset mid-run with enable high.
    en = 1'b1;
    run(25);
    n_rst = 1'b0;
    run(1);
    n_rst = 1'b1;
    run(20);
    en = 1'b0;
    run(2);

    // Illegal configurations, then a legal one while enabled.
    en = 1'b1;
    set_cfg(1, 1, 10);  run(3);
    set_cfg(10, 0, 10); run(3);
    set_cfg(10, 12, 10); run(3);
    set_cfg(10, 3, 0);  run(3);
    set_cfg(10, 3, 10); run(5);
    en = 1'b0;
    run(2);

    // Boundary cases: S==P, S==1, N==1.
    en = 1'b1;
    set_cfg(5, 5, 3);  run(20);
    en = 1'b0; run(2);
    en = 1'b1;
    set_cfg(3, 1, 4);  run(16);
    en = 1'b0; run(2);
    en = 1'b1;
    set_cfg(2, 2, 1);  run(6);
    en = 1'b0; run(2);

    // Config changes during RUN are ignored.
    set_cfg(10, 3, 10);
    en = 1'b1;
    run(20);
    set_cfg(4, 1, 10);
    run(90);
    en = 1'b0;
    run(1);
    en = 1'b1;
    run(45);
    en = 1'b0;
    run(2);

    // No-skip short packet.
    set_cfg(4, 2, 3);
    en = 1'b1;
    run(14);
    en = 1'b0;
    run(2);

    // Randomised traffic, config jittered every cycle.
    repeat (4000) begin
      if ($urandom_range(0, 15) == 0) set_cfg($urandom_range(1, 12), $urandom_range(0, 13),
                                               $urandom_range(0, 15));
      en    = ($urandom_range(0, 39) != 0);
      n_rst = ($urandom_range(0, 299) != 0);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
